// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory opcodes, memory-access stage state
// encoding and the default data-memory depth.
package cpu_pkg;

  localparam logic [5:0] OPC_LOAD  = 6'b000100;
  localparam logic [5:0] OPC_STORE = 6'b000101;

  localparam int DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_LD_WAIT = 2'd2,
    ST_WB      = 2'd3
  } state_t;

endpackage

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-access stage between the ALU and DataMemory.
// Accepts one instruction at a time, issues a STORE write or LOAD read,
// waits out the memory's one-cycle registered read, then presents one
// write-back beat. Non-memory ops with wb_en pass the ALU result through.
//
// Optional build macro MAU_ADDR_CHECK_EN: LOAD/STORE addresses >= DEPTH
// set a sticky err flag, suppress the store write and make the load return 0.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is high only in IDLE; wb_valid is high only in WB, and
// wb_rd/wb_data do not change while wb_valid=1 and wb_ready=0.
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int RD_W   = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opc,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_rs,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wb_en,
  output logic [5:0]        mem_opc,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              err,
  output logic [1:0]        dbg_state
);

  state_t state_q, state_d;

  logic [5:0]        opc_q;
  logic [DATA_W-1:0] alu_q;
  logic [RD_W-1:0]   rd_q;
  logic              wb_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_din_q;
  logic [RD_W-1:0]   wb_rd_q;
  logic [DATA_W-1:0] wb_data_q;

  logic is_ld, is_st, in_is_mem, addr_oor, addr_bad;

  assign is_ld     = (opc_q == OPC_LOAD);
  assign is_st     = (opc_q == OPC_STORE);
  assign in_is_mem = (in_opc == OPC_LOAD) || (in_opc == OPC_STORE);
  assign addr_oor  = (alu_q >= DATA_W'(DEPTH));

`ifdef MAU_ADDR_CHECK_EN
  logic err_q;

  assign addr_bad = (is_ld || is_st) && addr_oor;
  assign err      = err_q;

  // Sticky range error, raised when a bad LOAD/STORE reaches EXEC
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (state_q == ST_EXEC && addr_bad) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_addr_oor;

  assign unused_addr_oor = addr_oor;
  assign addr_bad        = 1'b0;
  assign err             = 1'b0;
`endif

  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign dbg_state = state_q;

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus handshake and memory strobes
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    wb_valid = 1'b0;
    mem_wea  = 1'b0;
    mem_opc  = 6'b000000;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_st) begin
          mem_opc = OPC_STORE;
          mem_wea = !addr_bad;
          state_d = ST_IDLE;
        end else if (is_ld) begin
          // A rejected load reads nothing; LD_WAIT substitutes zero
          mem_opc = addr_bad ? 6'b000000 : OPC_LOAD;
          state_d = ST_LD_WAIT;
        end else if (wb_en_q) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LD_WAIT: begin
        state_d = ST_WB;
      end
      ST_WB: begin
        wb_valid = 1'b1;
        if (wb_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Instruction capture, memory address/data and write-back registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      opc_q      <= '0;
      alu_q      <= '0;
      rd_q       <= '0;
      wb_en_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            opc_q   <= in_opc;
            alu_q   <= in_alu;
            rd_q    <= in_rd;
            wb_en_q <= in_wb_en;
            // Memory lines only move for memory ops, otherwise they hold
            if (in_is_mem) begin
              mem_addr_q <= ADDR_W'(in_alu);
              mem_din_q  <= in_rs;
            end
          end
        end
        ST_EXEC: begin
          if (!is_ld && !is_st && wb_en_q) begin
            wb_rd_q   <= rd_q;
            wb_data_q <= alu_q;
          end
        end
        ST_LD_WAIT: begin
          wb_rd_q   <= rd_q;
          wb_data_q <= addr_bad ? '0 : mem_dout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage between the ALU and `DataMemory`. It accepts one decoded instruction per handshake and issues STORE writes or LOAD reads to the data memory. It waits out the memory's one-cycle registered read, then presents a single write-back beat to the register file. Non-memory instructions with write-back enabled pass their ALU result through the same write-back path.

## Interface
Parameters:
- `DATA_W`, 32, data/ALU width
- `ADDR_W`, 32, address width driven to memory
- `DEPTH`, 8, number of data-memory words (legal addresses 0..DEPTH-1)
- `RD_W`, 5, destination register index width

Ports:
- `clock`  in  1  single clock, rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  upstream instruction valid
- `in_ready`  out  1  stage can accept
- `in_opc`  in  6  opcode (LOAD=6'b000100, STORE=6'b000101)
- `in_alu`  in  DATA_W  ALU result: address for LOAD/STORE, data otherwise
- `in_rs`  in  DATA_W  store data (RS)
- `in_rd`  in  RD_W  destination register
- `in_wb_en`  in  1  non-memory op writes back
- `mem_opc`  out  6  to DataMemory `OPC`
- `mem_wea`  out  1  to DataMemory `WEA`
- `mem_addr`  out  ADDR_W  to DataMemory `addressin`
- `mem_din`  out  DATA_W  to DataMemory `datain`
- `mem_dout`  in  DATA_W  from DataMemory `dataout`
- `wb_valid`  out  1  write-back beat valid
- `wb_ready`  in  1  register file accepts
- `wb_rd`  out  RD_W  write-back register index
- `wb_data`  out  DATA_W  write-back data
- `err`  out  1  sticky address-range error

## Operation
- States: IDLE, EXEC, LD_WAIT, WB.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, register opc/alu/rs/rd/wb_en and go to EXEC.
  - If `in_valid`=0, stay in IDLE.
- EXEC drives memory from the registered fields: `mem_addr`=alu, `mem_din`=rs.
  - STORE: `mem_wea`=1, `mem_opc`=STORE, then go to IDLE. No write-back.
  - LOAD: `mem_wea`=0, `mem_opc`=LOAD, then go to LD_WAIT.
  - Other opcode with wb_en=1: `wb_data`<=alu, then go to WB.
  - Other opcode with wb_en=0: go to IDLE.
- LD_WAIT: `mem_opc`=0, so the memory holds `dataout`. Capture `wb_data`<=`mem_dout`, then go to WB.
- WB: `wb_valid`=1, with `wb_rd`/`wb_data` held stable. On `wb_ready`=1, go to IDLE.
- Outside EXEC, `mem_wea`=0 and `mem_opc`=0. `mem_addr`/`mem_din` hold their last values.
- Accepts are not overlapped: `in_ready`=0 in EXEC, LD_WAIT and WB.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`=1.
  - `mem_wea`=0, `mem_opc`=0, `mem_addr`=0, `mem_din`=0.
  - `wb_valid`=0, `wb_rd`=0, `wb_data`=0.
  - `err`=0.
- Accept edge is T0.
  - STORE: memory writes at T1. `in_ready` returns high in the cycle after T1. Throughput is one store per 2 cycles.
  - LOAD: memory reads at T1, `mem_dout` is valid in the T1–T2 cycle, `wb_valid` rises after T2. Minimum 4 cycles per load.
  - ALU write-back: `wb_valid` rises after T1.
- WB stall: `wb_valid`, `wb_rd` and `wb_data` stay unchanged while `wb_ready`=0, for any number of cycles.
- Reset mid-operation (reset_n=0 sampled at an edge):
  - All registers are cleared and any pending write-back is dropped.
  - A store in EXEC at that same edge still writes, because the memory has no reset.

## Configuration
- `MAU_ADDR_CHECK_EN` defined:
  - In EXEC, a LOAD/STORE with alu ≥ DEPTH sets `err` (sticky until reset).
  - For such a STORE, `mem_wea` is forced to 0.
  - Such a LOAD drives `mem_opc`=0 and writes back data 0 via LD_WAIT/WB with normal timing.
- Undefined: no check. The address passes through unchanged and `err` is tied to 0.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants LOAD=6'b000100, STORE=6'b000101
  - state encoding for IDLE/EXEC/LD_WAIT/WB
  - DEPTH default
- Single module; no sub-module needed. The range check is a local comparator under the macro.

## Test plan
- Reset, then STORE alu=3, rs=0xDEADBEEF -> `mem_wea`=1 for exactly one cycle with addr 3; memory word 3 = 0xDEADBEEF; `wb_valid` never asserts.
- After the above, LOAD alu=3, rd=7 -> `wb_valid` rises 2 edges after accept, with `wb_rd`=7 and `wb_data`=0xDEADBEEF.
- Non-memory op alu=0x55, wb_en=1, rd=2, with `wb_ready` held 0 for 5 cycles -> `wb_data`=0x55 stays stable throughout; `in_ready`=0 until 1 cycle after the `wb_ready` handshake.
- Back-to-back `in_valid` with STORE then LOAD to the same address -> LOAD returns the stored value; `in_ready` deasserts between them.
- With `MAU_ADDR_CHECK_EN`: STORE alu=8 -> `mem_wea` stays 0 and `err`=1; then LOAD alu=9 -> `wb_data`=0 and `err` remains 1 until reset.
- `reset_n`=0 asserted in LD_WAIT -> next cycle is IDLE with `wb_valid`=0 and `in_ready`=1; no write-back occurs.
